// File: rtl/ahb_decode_ctrl.sv
// AHB address decoder and data-phase sequencer for a 4-slave read-data mux,
// including the default slave that answers unmapped transfers.
module ahb_decode_ctrl #(
    parameter logic [3:0] SLV1_BASE = 4'h0,
    parameter logic [3:0] SLV2_BASE = 4'h1,
    parameter logic [3:0] SLV3_BASE = 4'h2,
    parameter logic [3:0] SLV4_BASE = 4'h3
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready_mux,
    input  logic        hresp1,
    input  logic        hresp2,
    input  logic        hresp3,
    input  logic        hresp4,
    output logic        hsel1,
    output logic        hsel2,
    output logic        hsel3,
    output logic        hsel4,
    output logic [1:0]  mux_sel,
    output logic        hready,
    output logic        hresp
);

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    localparam logic [3:0] BASES [4] = '{SLV1_BASE, SLV2_BASE, SLV3_BASE, SLV4_BASE};

    logic [3:0] w_region;
    logic [3:0] w_hit;
    logic [3:0] w_sel;
    logic [3:0] w_slv_hresp;
    logic [1:0] w_idx;
    logic       w_unmapped;
    logic       w_err_start;
    logic       w_unused_bits;

    state_t     r_state;
    logic [1:0] r_mux_sel;
    logic       r_def_sel;
    logic       r_dflt_hready;
    logic       r_dflt_hresp;

    assign w_region      = haddr[31:28];
    assign w_unused_bits = ^{haddr[27:0], htrans[0]};

    // Lower slave number wins when bases overlap, keeping the selects one-hot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign w_hit[gi] = (w_region == BASES[gi]);
            if (gi == 0) begin : g_first
                assign w_sel[gi] = w_hit[gi];
            end else begin : g_rest
                assign w_sel[gi] = w_hit[gi] & ~(|w_hit[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    assign hsel1       = w_sel[0];
    assign hsel2       = w_sel[1];
    assign hsel3       = w_sel[2];
    assign hsel4       = w_sel[3];
    assign w_unmapped  = ~(|w_sel);
    assign w_err_start = w_unmapped & htrans[1];

    assign w_slv_hresp = {hresp4, hresp3, hresp2, hresp1};
    assign mux_sel     = r_mux_sel;
    assign hready      = r_def_sel ? r_dflt_hready : hready_mux;
    assign hresp       = r_def_sel ? r_dflt_hresp  : w_slv_hresp[r_mux_sel];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state       <= ST_OK;
            r_mux_sel     <= 2'b00;
            r_def_sel     <= 1'b0;
            r_dflt_hready <= 1'b1;
            r_dflt_hresp  <= 1'b0;
        end else begin
            // mux_sel keeps the last mapped slave so an unmapped phase never glitches it.
            if (hready) begin
                if (!w_unmapped) begin
                    r_mux_sel <= w_idx;
                end
                r_def_sel <= w_unmapped;
            end
            case (r_state)
                ST_OK: begin
                    if (hready && w_err_start) begin
                        r_state       <= ST_ERR1;
                        r_dflt_hready <= 1'b0;
                        r_dflt_hresp  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state       <= ST_ERR2;
                    r_dflt_hready <= 1'b1;
                    r_dflt_hresp  <= 1'b1;
                end
                ST_ERR2: begin
                    if (w_err_start) begin
                        r_state       <= ST_ERR1;
                        r_dflt_hready <= 1'b0;
                        r_dflt_hresp  <= 1'b1;
                    end else begin
                        r_state       <= ST_OK;
                        r_dflt_hready <= 1'b1;
                        r_dflt_hresp  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_OK;
                    r_dflt_hready <= 1'b1;
                    r_dflt_hresp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Scoreboard bench for ahb_decode_ctrl: a transaction-level model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_ahb_decode_ctrl;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [3:0] BASE_TBL [4] = '{4'h0, 4'h1, 4'h2, 4'h3};

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = IDLE;
    logic        hready_mux = 1'b1;
    logic        hresp1 = 1'b0, hresp2 = 1'b0, hresp3 = 1'b0, hresp4 = 1'b0;
    logic        hsel1, hsel2, hsel3, hsel4;
    logic [1:0]  mux_sel;
    logic        hready, hresp;

    always #5 hclk = ~hclk;

    ahb_decode_ctrl dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .haddr      (haddr),
        .htrans     (htrans),
        .hready_mux (hready_mux),
        .hresp1     (hresp1),
        .hresp2     (hresp2),
        .hresp3     (hresp3),
        .hresp4     (hresp4),
        .hsel1      (hsel1),
        .hsel2      (hsel2),
        .hsel3      (hsel3),
        .hsel4      (hsel4),
        .mux_sel    (mux_sel),
        .hready     (hready),
        .hresp      (hresp)
    );

    typedef struct packed {
        logic [3:0] hsel;
        logic [1:0] mux_sel;
        logic       hready;
        logic       hresp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    // Model state: who owns the data phase, and how many error cycles remain.
    bit m_dflt  = 1'b0;
    int m_err   = 0;
    int m_slave = 0;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[31:28] == BASE_TBL[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL cycle %0d %s: got %h expected %h", n_cycle, name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic rdy,
                         input logic [3:0] rsp, input logic rst, input bit chk);
        exp_t e;
        int   d;
        haddr      = a;
        htrans     = t;
        hready_mux = rdy;
        {hresp4, hresp3, hresp2, hresp1} = rsp;
        hreset     = rst;
        d = decode(a);
        e.hsel    = (d < 0) ? 4'd0 : 4'(1 << d);
        e.mux_sel = 2'(m_slave);
        if (m_dflt) begin
            e.hready = (m_err != 2);
            e.hresp  = (m_err != 0);
        end else begin
            e.hready = rdy;
            e.hresp  = rsp[m_slave];
        end
        if (chk) exp_q.push_back(e);
        @(posedge hclk);
        if (rst) begin
            m_dflt = 1'b0; m_err = 0; m_slave = 0;
        end else if (e.hready) begin
            if (d >= 0) begin
                m_slave = d; m_dflt = 1'b0; m_err = 0;
            end else begin
                m_dflt = 1'b1; m_err = t[1] ? 2 : 0;
            end
        end else if (m_err == 2) begin
            m_err = 1;
        end
        #1;
    endtask

    always @(negedge hclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("cycle %0d: hsel=%b mux_sel=%b hready=%b hresp=%b", n_cycle,
                     {hsel4, hsel3, hsel2, hsel1}, mux_sel, hready, hresp);
            check("hsel",    {hsel4, hsel3, hsel2, hsel1}, e.hsel);
            check("mux_sel", {2'b00, mux_sel},             {2'b00, e.mux_sel});
            check("hready",  {3'b000, hready},             {3'b000, e.hready});
            check("hresp",   {3'b000, hresp},              {3'b000, e.hresp});
        end
        n_cycle++;
    end

    initial begin
        logic [3:0]  rgn;
        logic [31:0] a;
        @(posedge hclk);
        #1;
        // Reset for two cycles; the second cycle shows the reset state.
        drive(32'h0, IDLE, 1'b1, 4'h0, 1'b1, 1'b0);
        drive(32'h0, IDLE, 1'b1, 4'h0, 1'b1, 1'b1);
        // Back-to-back NONSEQ to slave 2 then slave 4.
        drive(32'h1000_0000, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h3000_0004, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Slave 3 inserts three wait states while the address moves.
        drive(32'h2000_0000, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        repeat (3) drive(32'h0000_0000, NONSEQ, 1'b0, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Unmapped NONSEQ: two-cycle ERROR, then OKAY.
        drive(32'h8000_0000, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Unmapped IDLE: zero-wait OKAY regardless of hready_mux.
        drive(32'h8000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b0, 4'hF, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Two unmapped SEQ transfers, the second accepted on the ERR2 edge.
        drive(32'h8000_0000, SEQ,    1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h8000_0004, SEQ,    1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h8000_0004, SEQ,    1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Reset asserted during ERR1 aborts the error.
        drive(32'h8000_0000, NONSEQ, 1'b1, 4'h0, 1'b0, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b1, 1'b1);
        drive(32'h0000_0000, IDLE,   1'b1, 4'h0, 1'b0, 1'b1);
        // Randomized traffic across mapped and unmapped regions.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: rgn = 4'h0;
                1: rgn = 4'h1;
                2: rgn = 4'h2;
                3: rgn = 4'h3;
                4: rgn = 4'h8;
                default: rgn = 4'(($urandom_range(4, 15)));
            endcase
            a = {rgn, 28'($urandom)};
            drive(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0), 1'b1);
        end
        drive(32'h0, IDLE, 1'b1, 4'h0, 1'b0, 1'b0);
        @(negedge hclk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_decode_ctrl.md
Name: ahb_decode_ctrl

Overview:
- Address-phase decoder and data-phase sequencer for the 4-slave AHB read-data mux.
- Decodes HADDR into per-slave selects and registers the slave index for the data phase. That index drives the mux select.
- Contains the default slave: unmapped NONSEQ/SEQ transfers receive the standard two-cycle ERROR response. Idle or busy transfers to unmapped space receive a zero-wait OKAY.
- Produces the bus-level HREADY/HRESP returned to the master and fed back to all slaves.

Parameters:
- SLV1_BASE, 4'h0, HADDR[31:28] region owned by slave 1 (mux code 2'b00)
- SLV2_BASE, 4'h1, region for slave 2 (mux code 2'b01)
- SLV3_BASE, 4'h2, region for slave 3 (mux code 2'b10)
- SLV4_BASE, 4'h3, region for slave 4 (mux code 2'b11)

Ports:
- hclk  in  1  bus clock
- hreset  in  1  synchronous active-high reset
- haddr  in  32  address-phase address
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hready_mux  in  1  selected slave HREADYOUT (from read-data mux)
- hresp1..hresp4  in  1 each  slave HRESP
- hsel1..hsel4  out  1 each  combinational slave selects
- mux_sel  out  2  registered data-phase slave index to read-data mux
- hready  out  1  bus HREADY to master and slaves
- hresp  out  1  bus HRESP (0 OKAY, 1 ERROR)

Behaviour:
- Decode (combinational)
  - region = haddr[31:28].
  - hselN = (region == SLVn_BASE). Priority is 1>2>3>4 if bases overlap, so at most one hsel is high.
  - hsel does not depend on htrans; slaves qualify with htrans/hready.
  - unmapped = no hsel high.
- Address-phase acceptance: on a rising hclk where hready==1, the current address phase is accepted. At that edge:
  - mux_sel <= index of the asserted hsel; mux_sel holds its value if unmapped.
  - def_sel <= unmapped.
  - If unmapped and htrans[1]==1, the FSM goes to ERR1.
  - When hready==0, mux_sel and def_sel hold their values.
- Output select
  - def_sel==0: hready = hready_mux; hresp = hresp of the slave indexed by mux_sel.
  - def_sel==1: hready and hresp come from the FSM.
- Default-slave FSM, states OK, ERR1, ERR2
  - OK: hready=1, hresp=0 (zero-wait OKAY for IDLE/BUSY to unmapped). Next state is ERR1 on an accepted unmapped active transfer; otherwise stays in OK.
  - ERR1: hready=0, hresp=1. Always goes to ERR2 on the next edge.
  - ERR2: hready=1, hresp=1. The master's next address phase is accepted at this edge. Next state is ERR1 if that transfer is unmapped and active; otherwise OK.
- Latency
  - Select has 1-cycle address-to-data latency; there are no bubbles between back-to-back transfers to different slaves.
  - Each error costs 2 data-phase cycles.
- Reset
  - Values while hreset==1 at an edge: mux_sel=2'b00, def_sel=0, FSM=OK.
  - Resulting outputs: hready=hready_mux, hresp=hresp1.
  - Reset mid-ERR1/ERR2 aborts the error; the FSM returns to OK on the next edge.
- Wait states: while a mapped slave holds hready_mux=0, haddr/htrans changes are ignored and mux_sel stays stable.
- Simultaneous events: an ERR2 edge with a new unmapped active transfer re-enters ERR1 directly, without passing through OK.

Test Plan:
- Reset with hreset=1 for 2 cycles, hready_mux=1, hresp1=0 -> mux_sel=00, hready=1, hresp=0.
- Back-to-back NONSEQ transfers to 0x1000_0000 then 0x3000_0004, all slaves zero-wait -> hsel2 then hsel4 in consecutive cycles; mux_sel=01 then 11, each one cycle after its address phase.
- NONSEQ to 0x2000_0000 with slave 3 holding hready_mux=0 for 3 cycles while haddr changes to 0x0000_0000 -> mux_sel stays 10 for all 3 cycles and switches to 00 only after hready returns to 1.
- NONSEQ to 0x8000_0000 (unmapped) -> next cycle hready=0, hresp=1; following cycle hready=1, hresp=1; then OKAY. IDLE to 0x8000_0000 -> hready=1, hresp=0 with no error.
- Two consecutive unmapped SEQ transfers, second accepted at the ERR2 edge -> sequence ERR1, ERR2, ERR1, ERR2, OK. Asserting hreset during the second ERR1 -> hresp=0 on the following cycle.
